// File: rtl/flag_register.sv
// Registered ALU status flags with sticky-zero, a saturating zero-run counter
// and a load path for saving and restoring flags around interrupts.
module flag_register #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RUN_W      = 4,
  parameter int unsigned RUN_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             load,
  input  logic [4:0]       load_flags,
  input  logic             clear_sticky,
  output logic [4:0]       flags_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_p,
  output logic             sticky_z,
  output logic [RUN_W-1:0] zero_run,
  output logic             run_alert
);

  localparam logic [RUN_W-1:0] RunMax    = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RunThresh = RUN_THRESH[RUN_W-1:0];

  // Flag vector layout is {Z, N, C, V, P}, bit 4 = Z.
  logic [4:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [RUN_W-1:0] run_q, run_d;

  logic res_zero;
  logic res_par;
  logic do_update;

  // Decode the incoming result; an update is dropped whenever load is asserted.
  always_comb begin
    res_zero  = (result == '0);
    res_par   = ~^result;
    do_update = update & ~load;
  end

  // Next-state selection: load > update > hold for flags.
  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_q;
    run_d    = run_q;

    if (load) begin
      flags_d = load_flags;
    end else if (update) begin
      flags_d = {res_zero, result[WIDTH-1], carry_in, overflow_in, res_par};
    end

    // A zero result sets sticky_z even when a clear arrives in the same cycle.
    if (do_update && res_zero) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end

    if (do_update) begin
      if (res_zero) begin
        run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
      end else begin
        run_d = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
      run_q    <= '0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      run_q    <= run_d;
    end
  end

  // Outputs straight from the registers; only run_alert is decoded.
  always_comb begin
    flags_out = flags_q;
    flag_z    = flags_q[4];
    flag_n    = flags_q[3];
    flag_c    = flags_q[2];
    flag_v    = flags_q[1];
    flag_p    = flags_q[0];
    sticky_z  = sticky_q;
    zero_run  = run_q;
    run_alert = (run_q >= RunThresh);
  end

endmodule

// File: tb/tb_flag_register.sv
module tb_flag_register;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned RUN_W      = 4;
  localparam int unsigned RUN_THRESH = 3;

  logic             clk;
  logic             rst_n;
  logic             update;
  logic [WIDTH-1:0] result;
  logic             carry_in;
  logic             overflow_in;
  logic             load;
  logic [4:0]       load_flags;
  logic             clear_sticky;
  logic [4:0]       flags_out;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_p;
  logic             sticky_z;
  logic [RUN_W-1:0] zero_run;
  logic             run_alert;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed outputs packed as {flags_out, individual flags, sticky_z, zero_run, run_alert}.
  logic [15:0] obs;
  assign obs = {flags_out, flag_z, flag_n, flag_c, flag_v, flag_p, sticky_z, zero_run, run_alert};

  flag_register #(
    .WIDTH      (WIDTH),
    .RUN_W      (RUN_W),
    .RUN_THRESH (RUN_THRESH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .update       (update),
    .result       (result),
    .carry_in     (carry_in),
    .overflow_in  (overflow_in),
    .load         (load),
    .load_flags   (load_flags),
    .clear_sticky (clear_sticky),
    .flags_out    (flags_out),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .flag_p       (flag_p),
    .sticky_z     (sticky_z),
    .zero_run     (zero_run),
    .run_alert    (run_alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    update       = 1'b0;
    result       = '0;
    carry_in     = 1'b0;
    overflow_in  = 1'b0;
    load         = 1'b0;
    load_flags   = '0;
    clear_sticky = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    exp = 16'h0000;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs, exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_zero();
    logic [15:0] exp;
    update = 1'b1; result = 8'h00; carry_in = 1'b0; overflow_in = 1'b0;
    tick();
    exp = {5'b10001, 5'b10001, 1'b1, 4'd1, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL first_zero: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_walking_one();
    logic [15:0] exp;
    logic [4:0]  ef;
    for (int i = 0; i < 8; i++) begin
      update      = 1'b1;
      result      = 8'h01 << i;
      carry_in    = i[0];
      overflow_in = i[1];
      tick();
      ef  = {1'b0, (i == 7), i[0], i[1], 1'b0};
      exp = {ef, ef, 1'b1, 4'd0, 1'b0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL walking_one[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_zero_run();
    logic [15:0] exp;
    int          er;
    idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      update = 1'b1;
      result = 8'h00;
      tick();
      er  = (k > 15) ? 15 : k;
      exp = {5'b10001, 5'b10001, 1'b1, er[3:0], (er >= 3)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero_run[%0d]: got %h expected %h", k, obs, exp);
      end
    end
    result = 8'hAA;
    tick();
    exp = {5'b01001, 5'b01001, 1'b1, 4'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zero_run_break: got %h expected %h", obs, exp);
    end
    // Odd-parity non-zero value.
    result = 8'h07; carry_in = 1'b1;
    tick();
    exp = {5'b00100, 5'b00100, 1'b1, 4'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL odd_parity: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_priority();
    logic [15:0] exp;
    idle_inputs();
    update = 1'b1; result = 8'h00;
    tick();
    tick();
    // clear_sticky alone clears sticky but leaves zero_run at 2.
    idle_inputs();
    clear_sticky = 1'b1;
    tick();
    exp = {5'b10001, 5'b10001, 1'b0, 4'd2, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL clear_sticky: got %h expected %h", obs, exp);
    end
    // Load wins over update; sticky and zero_run untouched.
    idle_inputs();
    load = 1'b1; load_flags = 5'b01110; update = 1'b1; result = 8'h00;
    tick();
    exp = {5'b01110, 5'b01110, 1'b0, 4'd2, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL load_over_update: got %h expected %h", obs, exp);
    end
    // Set beats a simultaneous clear.
    idle_inputs();
    clear_sticky = 1'b1; update = 1'b1; result = 8'h00;
    tick();
    exp = {5'b10001, 5'b10001, 1'b1, 4'd3, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL set_over_clear: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp;
    idle_inputs();
    carry_in = 1'b1; overflow_in = 1'b1;
    exp = {5'b10001, 5'b10001, 1'b1, 4'd3, 1'b1};
    for (int i = 0; i < 5; i++) begin
      result = i[0] ? 8'h00 : 8'hFF;
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp;
    idle_inputs();
    update = 1'b1; result = 8'h00;
    tick();
    tick();
    exp = {5'b10001, 5'b10001, 1'b1, 4'd5, 1'b1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pre_reset: got %h expected %h", obs, exp);
    end
    rst_n = 1'b0; load = 1'b1; load_flags = 5'b11111;
    tick();
    exp = 16'h0000;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", obs, exp);
    end
    rst_n = 1'b1;
    idle_inputs();
    update = 1'b1; result = 8'h0F; carry_in = 1'b1;
    tick();
    exp = {5'b00101, 5'b00101, 1'b0, 4'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL post_reset: got %h expected %h", obs, exp);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_first_zero();
    test_walking_one();
    test_zero_run();
    test_priority();
    test_hold();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
- Parametrised, registered status-flag unit for the toy processor datapath; successor to the combinational 8-bit zero test.
- Captures Z/N/C/V/P flags from the ALU result on an update strobe and holds them for branch logic.
- Adds a sticky-zero flag, a saturating consecutive-zero run counter with threshold alert, and a flag save/restore load path for interrupt entry/exit.

Parameters:
- WIDTH, 8, ALU result width in bits (>=2).
- RUN_W, 4, zero-run counter width in bits (>=2).
- RUN_THRESH, 3, run_alert asserts when zero_run >= RUN_THRESH (1 .. 2^RUN_W-1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- update  in  1  capture flags from result/carry_in/overflow_in this cycle.
- result  in  WIDTH  ALU result word.
- carry_in  in  1  ALU carry-out.
- overflow_in  in  1  ALU signed overflow.
- load  in  1  restore flags from load_flags (higher priority than update).
- load_flags  in  5  {Z,N,C,V,P} restore value.
- clear_sticky  in  1  clear sticky_z.
- flags_out  out  5  {Z,N,C,V,P} registered flags (save path).
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  registered carry_in.
- flag_v  out  1  registered overflow_in.
- flag_p  out  1  even parity: 1 when result has an even number of 1 bits.
- sticky_z  out  1  set by any zero result since the last clear.
- zero_run  out  RUN_W  count of consecutive zero results on updates.
- run_alert  out  1  zero_run >= RUN_THRESH.

Behaviour:
- Reset: when rst_n = 0 at a rising clk edge, clear all flags, sticky_z and zero_run to 0, so run_alert = 0. Reset overrides load, update and clear_sticky in the same cycle.
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- Outputs are registered; run_alert is decoded combinationally from the zero_run register.
- Flag priority per edge: reset > load > update > hold.
  - load = 1: Z,N,C,V,P take load_flags. sticky_z and zero_run are unchanged, even if update = 1 in the same cycle (the update is dropped).
  - update = 1 (load = 0): Z = (result == 0), N = MSB, C = carry_in, V = overflow_in, P = ~^result.
  - Neither asserted: all flags hold.
- sticky_z next-state:
  - Set (=1) when update = 1, load = 0 and result == 0.
  - Otherwise cleared when clear_sticky = 1.
  - Otherwise hold.
  - Set wins over a simultaneous clear_sticky.
- zero_run next-state, only when update = 1 and load = 0:
  - result == 0: increment, saturating at 2^RUN_W-1 (no wrap).
  - result != 0: reset to 0.
  - Otherwise hold. clear_sticky has no effect on zero_run.
- flags_out = {flag_z, flag_n, flag_c, flag_v, flag_p}, bit 4 = Z.
- Parity and zero detection cover the full WIDTH. No x-propagation from unused bits.

Test Plan:
- Reset, then update with result = 8'h00, carry_in = 0, overflow_in = 0 -> next cycle flags_out = 5'b10001, sticky_z = 1, zero_run = 1, run_alert = 0.
- Walking-one: update with result = 8'h01, 8'h02 … 8'h80, one per cycle -> Z = 0 and P = 0 each cycle; N = 1 only for 8'h80; zero_run = 0; sticky_z holds its prior value.
- Zero run: 3 consecutive updates with 0 -> run_alert rises after the 3rd edge (zero_run = 3). Continue with zeros to 20 updates total -> zero_run saturates at 15. Then one update with 8'hAA -> zero_run = 0, run_alert = 0, P = 1, N = 1.
- Same-cycle priority: load = 1 with load_flags = 5'b01110, update = 1, result = 0 -> flags_out = 5'b01110 and zero_run unchanged. Separately, clear_sticky = 1 together with update of result 0 -> sticky_z stays 1.
- Hold: update = 0 for 5 cycles with result toggling between 8'hFF and 8'h00 -> all outputs constant.
- Mid-operation reset: zero_run = 5 and sticky_z = 1, then rst_n = 0 for one edge while update = 1 and result = 0 -> all outputs 0 after that edge.
